psum_bram_rmw_mux: RTL and testbench
====================================

Name: psum_bram_rmw_mux

Overview:
- Parametrised successor to the psum BRAM controller/bus mux.
- Arbitrates a single-port psum BRAM between the host (AXI BRAM-controller side) and NUM_CH accelerator psum writers.
- New over the previous block: multi-channel round-robin arbitration, read-modify-write accumulation into psum memory, configurable BRAM read latency, and safe ownership hand-over that never cuts an operation in half.
- Sits between the PE-array psum outputs, the host BRAM-controller port and the psum BRAM.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, psum word width (signed two's complement).
- NUM_BYTE, 4, byte-enable width (DATA_WIDTH/8).
- NUM_CH, 2, number of accelerator psum write channels (1..8).
- RD_LATENCY, 1, BRAM read latency in cycles (1..3).
- REG_WIDTH, 32, config/status register width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_conf_ctrl  in  REG_WIDTH  bit0 = accelerator owns BRAM; bit1 = overwrite mode (first channel pass, no accumulate).
- o_conf_status  out  REG_WIDTH  bit0 owner (1 = acc), bit1 busy, [31:16] completed-op count (saturating at 16'hFFFF).
- bram_addr_a  in  ADDR_WIDTH  host address.
- bram_wrdata_a  in  DATA_WIDTH  host write data.
- bram_rddata_a  out  DATA_WIDTH  host read data.
- bram_en_a  in  1  host enable.
- bram_we_a  in  NUM_BYTE  host byte write enables.
- acc_addr  in  NUM_CH*ADDR_WIDTH  per-channel psum address, channel c at slice c.
- acc_dat  in  NUM_CH*DATA_WIDTH  per-channel psum value.
- acc_valid  in  NUM_CH  per-channel request.
- acc_ready  out  NUM_CH  one-hot accept pulse.
- addra  out  ADDR_WIDTH  BRAM address.
- dina  out  DATA_WIDTH  BRAM write data.
- douta  in  DATA_WIDTH  BRAM read data.
- ena  out  1  BRAM enable.
- wea  out  NUM_BYTE  BRAM byte write enables.

Behaviour:
- States: S_HOST, S_ACC_IDLE, S_RD, S_WAIT, S_WR. Reset enters S_HOST with all registered outputs 0, op count 0, RR pointer 0.
- S_HOST:
  - BRAM outputs are combinational passthrough of host signals; bram_rddata_a = douta; acc_ready = 0.
  - i_conf_ctrl[0]=1 -> S_ACC_IDLE next cycle.
- Outside S_HOST: bram_rddata_a = 0; host writes are ignored, not queued.
- S_ACC_IDLE:
  - ena=0, wea=0.
  - If ctrl[0]=0 -> S_HOST.
  - Otherwise, if any acc_valid: grant the lowest-indexed valid channel at or after the RR pointer; pulse its acc_ready for this cycle; latch addr and dat; advance the RR pointer to grant+1 (mod NUM_CH).
  - Next state is S_WR if ctrl[1]=1, else S_RD.
- S_RD: ena=1, wea=0, addra=latched addr; load wait counter = RD_LATENCY; -> S_WAIT.
- S_WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, register sum = douta + latched dat (DATA_WIDTH wrap), then -> S_WR.
- S_WR:
  - ena=1, wea=all ones, addra=latched addr.
  - dina = sum, or latched dat in overwrite mode.
  - Increment op count; -> S_ACC_IDLE.
- Throughput:
  - Accumulate: one op per RD_LATENCY+3 cycles (4 at default).
  - Overwrite: one op per 2 cycles.
- ctrl[0] falling mid-op: the current op completes through S_WR; no new grant is made; then -> S_HOST.
- ctrl[1] is sampled only at grant.
- Op count clears on the rising edge of ctrl[0] (detected from a registered copy).
- busy (status bit1) = state in {S_RD, S_WAIT, S_WR}.
- owner (status bit0) = state != S_HOST.
- acc_valid deasserted before grant: request dropped, no side effects.
- Async reset mid-op: the op is discarded, the BRAM word is left unwritten, and the block returns to S_HOST.

Optional Feature:
- Macro PSUM_SATURATE_EN.
- Defined: the accumulate add is signed-saturating: clamp to 2^(DATA_WIDTH-1)-1 on positive overflow and -2^(DATA_WIDTH-1) on negative overflow; status bit2 is a sticky overflow flag, cleared with the op count.
- Undefined: the add wraps modulo 2^DATA_WIDTH and status bit2 reads 0.

Test Plan:
- Host access: ctrl=0, host writes 0x1234 to addr 5 then reads it -> BRAM word 5 = 0x1234; bram_rddata_a = 0x1234 one cycle after the read; acc_ready stays 0.
- Accumulate: BRAM[8]=10, ctrl=1, ch0 sends addr 8, dat 7 -> ready pulse in cycle 1, write in cycle 4 with dina=17; status[31:16]=1.
- Round-robin: both channels hold valid continuously, ctrl=1 -> grants alternate 0,1,0,1 across 4 ops, each accepted exactly once; RR pointer wraps.
- Overwrite mode: ctrl=3, ch1 sends addr 2, dat -5 -> BRAM[2] = 0xFFFFFFFB regardless of prior content; 2 cycles per op.
- Hand-over: drop ctrl[0] during S_WAIT -> the write still lands, then S_HOST; a host write issued during the op is ignored; with RD_LATENCY=3 the op takes 6 cycles.
- Saturation (PSUM_SATURATE_EN defined): BRAM[0]=0x7FFFFFF0, add 0x20 -> 0x7FFFFFFF and status bit2=1; without the macro -> 0x80000010.

Source files
------------

// File: rtl/psum_bram_rmw_mux_if.sv
// psum_bram_rmw_mux_if: host BRAM-controller port plus the accelerator psum
// write channels of psum_bram_rmw_mux, bundled as one interface.
// master = host / PE-array side, slave = the mux.
interface psum_bram_rmw_mux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int NUM_CH     = 2
);
    // Host (AXI BRAM-controller) side
    logic [ADDR_WIDTH-1:0]        bram_addr_a;
    logic [DATA_WIDTH-1:0]        bram_wrdata_a;
    logic [DATA_WIDTH-1:0]        bram_rddata_a;
    logic                         bram_en_a;
    logic [NUM_BYTE-1:0]          bram_we_a;

    // Accelerator psum writers, channel c at slice c
    logic [NUM_CH*ADDR_WIDTH-1:0] acc_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] acc_dat;
    logic [NUM_CH-1:0]            acc_valid;
    logic [NUM_CH-1:0]            acc_ready;

    modport master (
        output bram_addr_a, bram_wrdata_a, bram_en_a, bram_we_a,
        output acc_addr, acc_dat, acc_valid,
        input  bram_rddata_a, acc_ready
    );

    modport slave (
        input  bram_addr_a, bram_wrdata_a, bram_en_a, bram_we_a,
        input  acc_addr, acc_dat, acc_valid,
        output bram_rddata_a, acc_ready
    );
endinterface

// File: rtl/psum_bram_rmw_mux.sv
// psum_bram_rmw_mux: arbitrates a single-port psum BRAM between the host
// BRAM-controller port and NUM_CH accelerator psum writers. Accelerator
// writes are round-robin granted and either accumulate into the stored word
// (read-modify-write) or overwrite it. Ownership changes only between ops.
// Optional feature macro: PSUM_SATURATE_EN (signed-saturating accumulate
// with a sticky overflow flag in status bit2).
module psum_bram_rmw_mux #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int NUM_CH     = 2,
    parameter int RD_LATENCY = 1,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
    output logic [REG_WIDTH-1:0]  o_conf_status,
    psum_bram_rmw_mux_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    input  logic [DATA_WIDTH-1:0] douta,
    output logic                  ena,
    output logic [NUM_BYTE-1:0]   wea
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_HOST,
        S_ACC_IDLE,
        S_RD,
        S_WAIT,
        S_WR
    } state_t;

    state_t                state_q;
    logic [PTR_W-1:0]      rr_ptr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [1:0]            wait_q;
    logic                  ctrl0_q;
    logic [15:0]           op_cnt_q;
    logic                  ovf_q;

    // Registered BRAM-side drive used whenever the accelerator owns the port
    logic                  ena_q;
    logic [NUM_BYTE-1:0]   wea_q;
    logic [ADDR_WIDTH-1:0] addra_q;
    logic [DATA_WIDTH-1:0] dina_q;

    // Grant decision for the current cycle
    logic                  gnt_found_d;
    logic [NUM_CH-1:0]     gnt_onehot_d;
    logic [ADDR_WIDTH-1:0] gnt_addr_d;
    logic [DATA_WIDTH-1:0] gnt_dat_d;
    logic [PTR_W-1:0]      rr_ptr_d;
    int unsigned           cand;

    // Accumulate result and overflow indication
    logic [DATA_WIDTH-1:0] sum_wrap;
    logic [DATA_WIDTH-1:0] sum_d;
    logic                  ovf_d;

    logic                  acc_on;
    logic                  ovw_mode;
    logic                  cnt_clr;
    logic                  busy;
    logic                  grant;
    logic                  ctrl_unused;

    assign acc_on      = i_conf_ctrl[0];
    assign ovw_mode    = i_conf_ctrl[1];
    assign cnt_clr     = acc_on & ~ctrl0_q;
    assign busy        = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
    assign grant       = (state_q == S_ACC_IDLE) && acc_on && gnt_found_d;
    assign ctrl_unused = ^i_conf_ctrl[REG_WIDTH-1:2];

    // Round-robin search: first valid channel at or after the RR pointer
    always_comb begin
        gnt_found_d  = 1'b0;
        gnt_onehot_d = '0;
        gnt_addr_d   = '0;
        gnt_dat_d    = '0;
        rr_ptr_d     = rr_ptr_q;
        cand         = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_CH;
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (!gnt_found_d && (j == cand) && bus.acc_valid[j]) begin
                    gnt_found_d     = 1'b1;
                    gnt_onehot_d[j] = 1'b1;
                    gnt_addr_d      = bus.acc_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    gnt_dat_d       = bus.acc_dat[j*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d        = PTR_W'((j + 1) % NUM_CH);
                end
            end
        end
    end

    // Accept pulse goes only to the channel granted this cycle
    always_comb begin
        bus.acc_ready = grant ? gnt_onehot_d : '0;
    end

    // Read-modify-write adder (wrapping, or signed-saturating when enabled)
    always_comb begin
        sum_wrap = douta + dat_q;
        sum_d    = sum_wrap;
        ovf_d    = 1'b0;
`ifdef PSUM_SATURATE_EN
        if (!douta[DATA_WIDTH-1] && !dat_q[DATA_WIDTH-1] && sum_wrap[DATA_WIDTH-1]) begin
            sum_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (douta[DATA_WIDTH-1] && dat_q[DATA_WIDTH-1] && !sum_wrap[DATA_WIDTH-1]) begin
            sum_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            ovf_d = 1'b1;
        end
`endif
    end

    // Ownership FSM with registered BRAM drive, op counter and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HOST;
            rr_ptr_q <= '0;
            dat_q    <= '0;
            wait_q   <= '0;
            ctrl0_q  <= 1'b0;
            op_cnt_q <= '0;
            ovf_q    <= 1'b0;
            ena_q    <= 1'b0;
            wea_q    <= '0;
            addra_q  <= '0;
            dina_q   <= '0;
        end else begin
            ctrl0_q <= acc_on;
            case (state_q)
                S_HOST: begin
                    ena_q <= 1'b0;
                    wea_q <= '0;
                    if (acc_on) begin
                        state_q <= S_ACC_IDLE;
                    end
                end
                S_ACC_IDLE: begin
                    if (!acc_on) begin
                        state_q <= S_HOST;
                    end else if (gnt_found_d) begin
                        dat_q    <= gnt_dat_d;
                        rr_ptr_q <= rr_ptr_d;
                        addra_q  <= gnt_addr_d;
                        ena_q    <= 1'b1;
                        // Overwrite skips the read and writes the channel value directly
                        if (ovw_mode) begin
                            wea_q   <= '1;
                            dina_q  <= gnt_dat_d;
                            state_q <= S_WR;
                        end else begin
                            wea_q   <= '0;
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    ena_q   <= 1'b0;
                    wait_q  <= 2'(RD_LATENCY);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    wait_q <= wait_q - 2'd1;
                    if (wait_q == 2'd1) begin
                        dina_q  <= sum_d;
                        ena_q   <= 1'b1;
                        wea_q   <= '1;
                        state_q <= S_WR;
                        if (ovf_d) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    ena_q   <= 1'b0;
                    wea_q   <= '0;
                    state_q <= S_ACC_IDLE;
                    if (op_cnt_q != 16'hFFFF) begin
                        op_cnt_q <= op_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_HOST;
                end
            endcase
            // A new ownership session restarts the statistics; takes priority
            if (cnt_clr) begin
                op_cnt_q <= '0;
                ovf_q    <= 1'b0;
            end
        end
    end

    // BRAM port: host passthrough in S_HOST, registered accelerator drive otherwise
    always_comb begin
        if (state_q == S_HOST) begin
            addra             = bus.bram_addr_a;
            dina              = bus.bram_wrdata_a;
            ena               = bus.bram_en_a;
            wea               = bus.bram_we_a;
            bus.bram_rddata_a = douta;
        end else begin
            addra             = addra_q;
            dina              = dina_q;
            ena               = ena_q;
            wea               = wea_q;
            bus.bram_rddata_a = '0;
        end
    end

    // Status register: owner, busy, overflow, completed-op count
    always_comb begin
        o_conf_status        = '0;
        o_conf_status[0]     = (state_q != S_HOST);
        o_conf_status[1]     = busy;
        o_conf_status[2]     = ovf_q;
        o_conf_status[31:16] = op_cnt_q;
    end

endmodule

// File: tb/tb_psum_bram_rmw_mux.sv
// Directed self-checking bench for psum_bram_rmw_mux. Instance A uses
// RD_LATENCY=1, instance B uses RD_LATENCY=3; each has its own BRAM model.
`timescale 1ns/1ps
module tb_psum_bram_rmw_mux;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ctrl_a, ctrl_b, status_a, status_b;
    logic [AW-1:0] a_addra, b_addra;
    logic [DW-1:0] a_dina, b_dina, a_douta, b_douta;
    logic          a_ena, b_ena;
    logic [NB-1:0] a_wea, b_wea;

    psum_bram_rmw_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_CH(NCH)) bus_a ();
    psum_bram_rmw_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_CH(NCH)) bus_b ();

    psum_bram_rmw_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_CH(NCH),
                        .RD_LATENCY(1), .REG_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(ctrl_a), .o_conf_status(status_a),
        .bus(bus_a), .addra(a_addra), .dina(a_dina), .douta(a_douta),
        .ena(a_ena), .wea(a_wea));

    psum_bram_rmw_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_CH(NCH),
                        .RD_LATENCY(3), .REG_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(ctrl_b), .o_conf_status(status_b),
        .bus(bus_b), .addra(b_addra), .dina(b_dina), .douta(b_douta),
        .ena(b_ena), .wea(b_wea));

    // BRAM models with a backdoor load port
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic        poke_a, poke_b;
    logic [3:0]  poke_addr;
    logic [31:0] poke_data;
    logic [31:0] a_rd, b_p0, b_p1, b_p2;

    always @(posedge clk) begin
        if (poke_a) begin
            mem_a[poke_addr] <= poke_data;
        end else if (a_ena) begin
            for (int b = 0; b < NB; b++)
                if (a_wea[b]) mem_a[a_addra[3:0]][8*b +: 8] <= a_dina[8*b +: 8];
            a_rd <= mem_a[a_addra[3:0]];
        end
    end
    assign a_douta = a_rd;

    always @(posedge clk) begin
        if (poke_b) begin
            mem_b[poke_addr] <= poke_data;
        end else if (b_ena) begin
            for (int b = 0; b < NB; b++)
                if (b_wea[b]) mem_b[b_addra[3:0]][8*b +: 8] <= b_dina[8*b +: 8];
            b_p0 <= mem_b[b_addra[3:0]];
        end
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_douta = b_p2;

    // Grant log for instance A
    logic [NCH-1:0] gnt_q [$];
    int             gnt_cyc [$];
    always @(negedge clk) begin
        if (bus_a.acc_ready != '0) begin
            gnt_q.push_back(bus_a.acc_ready);
            gnt_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic poke_mem(input bit sel_b, input logic [3:0] addr, input logic [31:0] data);
        tick();
        poke_addr = addr;
        poke_data = data;
        if (sel_b) poke_b = 1'b1; else poke_a = 1'b1;
        tick();
        poke_a = 1'b0;
        poke_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int n0;
    logic [31:0] sat_exp, ovf_exp;

    initial begin
        rst_n = 1'b0;
        ctrl_a = '0; ctrl_b = '0;
        poke_a = 1'b0; poke_b = 1'b0; poke_addr = '0; poke_data = '0;
        bus_a.bram_addr_a = '0; bus_a.bram_wrdata_a = '0; bus_a.bram_en_a = 1'b0; bus_a.bram_we_a = '0;
        bus_a.acc_addr = '0; bus_a.acc_dat = '0; bus_a.acc_valid = '0;
        bus_b.bram_addr_a = '0; bus_b.bram_wrdata_a = '0; bus_b.bram_en_a = 1'b0; bus_b.bram_we_a = '0;
        bus_b.acc_addr = '0; bus_b.acc_dat = '0; bus_b.acc_valid = '0;
        repeat (3) @(posedge clk);
        look();
        check_eq("rst_status_a", status_a, 32'h0);
        check_eq("rst_status_b", status_b, 32'h0);
        check_eq("rst_ready_a", 32'(bus_a.acc_ready), 32'h0);
        tick();
        rst_n = 1'b1;

        // Host write then read, accelerator request ignored while host owns the port
        bus_a.bram_en_a = 1'b1; bus_a.bram_we_a = 4'hF;
        bus_a.bram_addr_a = 32'd5; bus_a.bram_wrdata_a = 32'h1234;
        bus_a.acc_valid = 2'b01;
        look();
        check_eq("host_addra", a_addra, 32'd5);
        check_eq("host_wea", 32'(a_wea), 32'hF);
        check_eq("host_dina", a_dina, 32'h1234);
        check_eq("host_ready", 32'(bus_a.acc_ready), 32'h0);
        tick();
        bus_a.bram_we_a = '0;
        look();
        check_eq("host_mem5", mem_a[5], 32'h1234);
        tick();
        bus_a.bram_en_a = 1'b0;
        bus_a.acc_valid = '0;
        look();
        check_eq("host_rddata", bus_a.bram_rddata_a, 32'h1234);

        // Accumulate: 10 + 7 at address 8
        poke_mem(1'b0, 4'd8, 32'd10);
        ctrl_a = 32'd1;
        bus_a.acc_valid = 2'b01;
        bus_a.acc_addr[0 +: AW] = 32'd8;
        bus_a.acc_dat[0 +: DW] = 32'd7;
        look();
        check_eq("acc_ready_in_host", 32'(bus_a.acc_ready), 32'h0);
        tick();
        look();
        check_eq("acc_ready_c1", 32'(bus_a.acc_ready), 32'h1);
        check_eq("acc_status_idle", status_a & 32'h3, 32'h1);
        tick();
        bus_a.acc_valid = '0;
        look();
        check_eq("acc_rd_ena", 32'(a_ena), 32'h1);
        check_eq("acc_rd_wea", 32'(a_wea), 32'h0);
        check_eq("acc_rd_addra", a_addra, 32'd8);
        check_eq("acc_busy", status_a & 32'h3, 32'h3);
        tick();
        look();
        check_eq("acc_wait_ena", 32'(a_ena), 32'h0);
        tick();
        look();
        check_eq("acc_wr_wea_c4", 32'(a_wea), 32'hF);
        check_eq("acc_wr_dina", a_dina, 32'd17);
        check_eq("acc_wr_addra", a_addra, 32'd8);
        tick();
        look();
        check_eq("acc_mem8", mem_a[8], 32'd17);
        check_eq("acc_opcnt", status_a[31:16], 32'd1);

        // Round-robin with both channels always requesting
        poke_mem(1'b0, 4'd1, 32'd0);
        poke_mem(1'b0, 4'd3, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n0 = gnt_q.size();
        bus_a.acc_valid = 2'b11;
        bus_a.acc_addr[0 +: AW] = 32'd1;  bus_a.acc_dat[0 +: DW] = 32'd1;
        bus_a.acc_addr[AW +: AW] = 32'd3; bus_a.acc_dat[DW +: DW] = 32'd100;
        for (int k = 0; k < 40 && gnt_q.size() < n0 + 4; k++) begin
            tick();
            look();
        end
        tick();
        bus_a.acc_valid = '0;
        check_eq("rr_count", 32'(gnt_q.size() - n0), 32'd4);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("rr_gnt%0d", k), 32'(gnt_q[n0+k]), (k % 2 == 0) ? 32'h1 : 32'h2);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("rr_gap%0d", k), 32'(gnt_cyc[n0+k+1] - gnt_cyc[n0+k]), 32'd4);
        repeat (3) tick();
        look();
        check_eq("rr_mem1", mem_a[1], 32'd2);
        check_eq("rr_mem3", mem_a[3], 32'd200);
        check_eq("rr_opcnt", status_a[31:16], 32'd4);

        // Overwrite mode: ch1 writes -5, two cycles per op
        poke_mem(1'b0, 4'd2, 32'h55);
        ctrl_a = 32'd3;
        n0 = gnt_q.size();
        bus_a.acc_valid = 2'b10;
        bus_a.acc_addr[AW +: AW] = 32'd2;
        bus_a.acc_dat[DW +: DW] = 32'hFFFF_FFFB;
        look();
        check_eq("ovw_ready", 32'(bus_a.acc_ready), 32'h2);
        tick();
        look();
        check_eq("ovw_wea", 32'(a_wea), 32'hF);
        check_eq("ovw_dina", a_dina, 32'hFFFF_FFFB);
        tick();
        look();
        check_eq("ovw_mem2", mem_a[2], 32'hFFFF_FFFB);
        tick();
        bus_a.acc_valid = '0;
        tick();
        look();
        check_eq("ovw_gap", 32'(gnt_cyc[n0+1] - gnt_cyc[n0]), 32'd2);
        check_eq("ovw_opcnt", status_a[31:16], 32'd6);

        // Positive overflow on the accumulate path
        poke_mem(1'b0, 4'd0, 32'h7FFF_FFF0);
        ctrl_a = 32'd1;
        bus_a.acc_valid = 2'b01;
        bus_a.acc_addr[0 +: AW] = 32'd0;
        bus_a.acc_dat[0 +: DW] = 32'h20;
        look();
        check_eq("sat_ready", 32'(bus_a.acc_ready), 32'h1);
        tick();
        bus_a.acc_valid = '0;
        repeat (3) tick();
        look();
`ifdef PSUM_SATURATE_EN
        sat_exp = 32'h7FFF_FFFF; ovf_exp = 32'h4;
`else
        sat_exp = 32'h8000_0010; ovf_exp = 32'h0;
`endif
        check_eq("sat_mem0", mem_a[0], sat_exp);
        check_eq("sat_flag", status_a & 32'h4, ovf_exp);

        // Asynchronous reset in the middle of an op discards it
        poke_mem(1'b0, 4'd6, 32'd50);
        bus_a.acc_valid = 2'b01;
        bus_a.acc_addr[0 +: AW] = 32'd6;
        bus_a.acc_dat[0 +: DW] = 32'd9;
        look();
        check_eq("rstmid_ready", 32'(bus_a.acc_ready), 32'h1);
        tick();
        bus_a.acc_valid = '0;
        tick();
        rst_n = 1'b0;
        ctrl_a = '0;
        look();
        check_eq("rstmid_status", status_a, 32'h0);
        check_eq("rstmid_ena", 32'(a_ena), 32'h0);
        tick();
        tick();
        look();
        check_eq("rstmid_mem6", mem_a[6], 32'd50);
        tick();
        rst_n = 1'b1;

        // Hand-over on the RD_LATENCY=3 instance: ctrl[0] falls during S_WAIT
        poke_mem(1'b1, 4'd4, 32'd100);
        ctrl_b = 32'd1;
        bus_b.acc_valid = 2'b01;
        bus_b.acc_addr[0 +: AW] = 32'd4;
        bus_b.acc_dat[0 +: DW] = 32'd5;
        tick();
        look();
        check_eq("ho_ready_c1", 32'(bus_b.acc_ready), 32'h1);
        tick();
        bus_b.acc_valid = '0;
        bus_b.bram_en_a = 1'b1; bus_b.bram_we_a = 4'hF;
        bus_b.bram_addr_a = 32'd4; bus_b.bram_wrdata_a = 32'hDEAD;
        look();
        check_eq("ho_rd_ena", 32'(b_ena), 32'h1);
        check_eq("ho_rd_wea", 32'(b_wea), 32'h0);
        tick();
        ctrl_b = '0;
        look();
        check_eq("ho_wait_wea", 32'(b_wea), 32'h0);
        check_eq("ho_rddata_zero", bus_b.bram_rddata_a, 32'h0);
        check_eq("ho_wait_busy", status_b & 32'h3, 32'h3);
        tick();
        tick();
        look();
        check_eq("ho_wait3_wea", 32'(b_wea), 32'h0);
        tick();
        bus_b.bram_en_a = 1'b0; bus_b.bram_we_a = '0;
        look();
        check_eq("ho_wr_wea_c6", 32'(b_wea), 32'hF);
        check_eq("ho_wr_dina", b_dina, 32'd105);
        tick();
        look();
        check_eq("ho_mem4", mem_b[4], 32'd105);
        tick();
        look();
        check_eq("ho_status_host", status_b, 32'h0001_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
